// File: rtl/stack_pkg.sv
// Shared types for the parametrised LIFO stack: operation encoding and the
// strobe-priority decoder used by param_stack.
package stack_pkg;

  typedef enum logic [2:0] {
    OP_NONE,
    OP_PUSH,
    OP_POP,
    OP_TOS,
    OP_REPLACE
  } op_t;

  // push&pop > push > pop > tos; tos is only honoured when alone.
  function automatic op_t decode_op(input logic push, input logic pop, input logic tos);
    if (push && pop) return OP_REPLACE;
    else if (push)   return OP_PUSH;
    else if (pop)    return OP_POP;
    else if (tos)    return OP_TOS;
    else             return OP_NONE;
  endfunction

endpackage

// File: rtl/stack_mem.sv
// Stack storage: one synchronous write port, one asynchronous read port.
// The read port sees the pre-write contents, which replace-top relies on.
module stack_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // NOTE: storage has no reset; count gates every read, so stale contents are
  // never observable, and a reset here would prevent RAM inference.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/param_stack.sv
// Parametrised LIFO operand/return-address stack with status flags, error
// reporting, synchronous clear and simultaneous push+pop replace-top.
module param_stack
  import stack_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 32,
  parameter int CW    = $clog2(DEPTH+1)  // derived; leave at default
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic             tos,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             out_valid,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow,
  output logic             error
);

  localparam int AW = $clog2(DEPTH);

  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             out_valid_q, out_valid_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             error_q, error_d;

  logic             mem_we;
  logic [AW-1:0]    mem_waddr;
  logic [AW-1:0]    top_addr;
  logic [WIDTH-1:0] mem_rdata;
  logic             is_empty, is_full;
  op_t              op;

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == CW'(DEPTH));
  assign top_addr = AW'(count_q - CW'(1));
  assign op       = decode_op(push, pop, tos);

  stack_mem #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_mem (
    .clk    (clk),
    .we_i   (mem_we),
    .waddr_i(mem_waddr),
    .wdata_i(data_in),
    .raddr_i(top_addr),
    .rdata_o(mem_rdata)
  );

  // NOTE: every output of this block gets a default first so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    count_d     = count_q;
    data_out_d  = data_out_q;
    out_valid_d = 1'b0;
    overflow_d  = 1'b0;
    underflow_d = 1'b0;
    error_d     = error_q | overflow_q | underflow_q;
    mem_we      = 1'b0;
    mem_waddr   = AW'(count_q);

    if (clear) begin
      count_d    = '0;
      data_out_d = '0;
      error_d    = 1'b0;
    end else begin
      unique case (op)
        OP_PUSH: begin
          if (is_full) begin
            overflow_d = 1'b1;
          end else begin
            mem_we  = 1'b1;
            count_d = count_q + CW'(1);
          end
        end
        OP_POP, OP_TOS: begin
          if (is_empty) begin
            underflow_d = 1'b1;
          end else begin
            data_out_d  = mem_rdata;
            out_valid_d = 1'b1;
            if (op == OP_POP) count_d = count_q - CW'(1);
          end
        end
        OP_REPLACE: begin
          out_valid_d = 1'b1;
          if (is_empty) begin
            data_out_d = data_in;   // bypass: nothing stored to replace
          end else begin
            data_out_d = mem_rdata;
            mem_we     = 1'b1;
            mem_waddr  = top_addr;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from the values present before the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q     <= '0;
      data_out_q  <= '0;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      count_q     <= count_d;
      data_out_q  <= data_out_d;
      out_valid_q <= out_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      error_q     <= error_d;
    end
  end

  assign data_out  = data_out_q;
  assign out_valid = out_valid_q;
  assign count     = count_q;
  assign empty     = is_empty;
  assign full      = is_full;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;
  assign error     = error_q;

endmodule

// File: tb/tb_param_stack.sv
// Scoreboard bench for param_stack (DEPTH=4): reads push their expected word
// into a queue; a negedge monitor pops and compares on every out_valid.
module tb_param_stack;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH+1);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             clear = 1'b0;
  logic             push = 1'b0;
  logic             pop = 1'b0;
  logic             tos = 1'b0;
  logic [WIDTH-1:0] data_in = '0;
  logic [WIDTH-1:0] data_out;
  logic             out_valid;
  logic [CW-1:0]    count;
  logic             empty, full, overflow, underflow, error;

  int checks = 0;
  int errors = 0;
  logic [WIDTH-1:0] exp_q[$];

  param_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .push     (push),
    .pop      (pop),
    .tos      (tos),
    .data_in  (data_in),
    .data_out (data_out),
    .out_valid(out_valid),
    .count    (count),
    .empty    (empty),
    .full     (full),
    .overflow (overflow),
    .underflow(underflow),
    .error    (error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change on the falling edge; the DUT acts on the next rising edge and
  // the task returns on the following falling edge with outputs settled.
  task automatic step(input logic p, input logic po, input logic t, input logic [WIDTH-1:0] d);
    push = p; pop = po; tos = t; data_in = d;
    @(negedge clk);
    push = 1'b0; pop = 1'b0; tos = 1'b0; data_in = '0;
  endtask

  task automatic do_push(input logic [WIDTH-1:0] d);
    step(1'b1, 1'b0, 1'b0, d);
  endtask

  task automatic do_pop(input logic [WIDTH-1:0] exp);
    exp_q.push_back(exp);
    step(1'b0, 1'b1, 1'b0, '0);
  endtask

  task automatic do_tos(input logic [WIDTH-1:0] exp);
    exp_q.push_back(exp);
    step(1'b0, 1'b0, 1'b1, '0);
  endtask

  task automatic do_replace(input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] exp);
    exp_q.push_back(exp);
    step(1'b1, 1'b1, 1'b0, d);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  // Monitor: every out_valid pulse must match the oldest outstanding read.
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      if (exp_q.size() == 0) check("unexpected_out_valid", 32'(out_valid), 32'd0);
      else                   check("data_out", 32'(data_out), 32'(exp_q.pop_front()));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    @(negedge clk);
    check("rst_count", 32'(count), 32'd0);
    check("rst_data_out", 32'(data_out), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_error", 32'({overflow, underflow, error}), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Basic LIFO order
    do_push(8'h11); do_push(8'h22); do_push(8'h33);
    check("lifo_count3", 32'(count), 32'd3);
    do_pop(8'h33);
    check("lifo_count2", 32'(count), 32'd2);
    do_pop(8'h22); do_pop(8'h11);
    check("lifo_count0", 32'(count), 32'd0);
    check("lifo_empty", 32'(empty), 32'd1);
    idle();
    check("lifo_valid_drop", 32'(out_valid), 32'd0);

    // Fill to DEPTH, overflow, no corruption
    for (int i = 1; i <= DEPTH; i++) do_push(WIDTH'(i));
    check("full_flag", 32'(full), 32'd1);
    check("full_count", 32'(count), 32'd4);
    do_push(8'h05);
    check("ovf_pulse", 32'(overflow), 32'd1);
    check("ovf_count", 32'(count), 32'd4);
    check("ovf_err_lag", 32'(error), 32'd0);
    idle();
    check("ovf_pulse_end", 32'(overflow), 32'd0);
    check("ovf_error", 32'(error), 32'd1);
    do_pop(8'h04);
    check("ovf_pop_count", 32'(count), 32'd3);
    do_pop(8'h03); do_pop(8'h02); do_pop(8'h01);

    // Underflow on empty stack
    do_pop(8'h00); void'(exp_q.pop_back());  // rejected: no read expected
    check("unf_pop_pulse", 32'(underflow), 32'd1);
    check("unf_pop_valid", 32'(out_valid), 32'd0);
    check("unf_data_hold", 32'(data_out), 32'h01);
    step(1'b0, 1'b0, 1'b1, '0);
    check("unf_tos_pulse", 32'(underflow), 32'd1);
    idle();
    check("unf_pulse_end", 32'(underflow), 32'd0);
    check("unf_error_sticky", 32'(error), 32'd1);
    do_clear();
    check("clr_error", 32'(error), 32'd0);
    check("clr_data_out", 32'(data_out), 32'd0);

    // tos and replace-top
    do_push(8'hA5);
    do_tos(8'hA5); do_tos(8'hA5);
    check("tos_count", 32'(count), 32'd1);
    do_replace(8'h5A, 8'hA5);
    check("rep_count", 32'(count), 32'd1);
    do_pop(8'h5A);
    check("rep_pop_count", 32'(count), 32'd0);

    // Replace on empty: bypass
    do_replace(8'h77, 8'h77);
    check("byp_count", 32'(count), 32'd0);
    check("byp_flags", 32'({overflow, underflow}), 32'd0);
    idle();
    check("byp_error", 32'(error), 32'd0);

    // Replace on full: no overflow, new top stored
    for (int i = 1; i <= DEPTH; i++) do_push(8'h40 + WIDTH'(i));
    do_replace(8'h99, 8'h44);
    check("repfull_count", 32'(count), 32'd4);
    check("repfull_ovf", 32'(overflow), 32'd0);
    do_pop(8'h99); do_pop(8'h43);
    idle();
    check("repfull_error", 32'(error), 32'd0);
    do_clear();

    // Asynchronous reset mid-cycle
    do_push(8'hC1); do_push(8'hC2); do_push(8'hC3);
    do_tos(8'hC3);
    #2 rst = 1'b1;
    #1;
    check("arst_count", 32'(count), 32'd0);
    check("arst_data_out", 32'(data_out), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Synchronous clear with a push in the same cycle
    do_push(8'hD1); do_push(8'hD2); do_push(8'hD3);
    do_tos(8'hD3);
    clear = 1'b1; push = 1'b1; data_in = 8'hEE;
    @(negedge clk);
    clear = 1'b0; push = 1'b0; data_in = '0;
    check("sclr_count", 32'(count), 32'd0);
    check("sclr_data_out", 32'(data_out), 32'd0);
    check("sclr_out_valid", 32'(out_valid), 32'd0);
    step(1'b0, 1'b1, 1'b0, '0);
    check("sclr_push_ignored", 32'(underflow), 32'd1);

    idle();
    check("pending_reads", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
